// File: rtl/apb_fabric.sv
// apb_fabric: registered, address-decoded APB interconnect, one requester to NUM_SLAVES completers.
// Optional ACCESS timeout enabled by defining APB_FABRIC_TIMEOUT_EN.
module apb_fabric #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 2,
  parameter int SEL_LSB        = 28,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rts,
  input  logic [ADDR_WIDTH-1:0]          m_paddr,
  input  logic [DATA_WIDTH-1:0]          m_pwdata,
  output logic [DATA_WIDTH-1:0]          m_prdata,
  input  logic                           m_psel,
  input  logic                           m_penable,
  input  logic                           m_pwrite,
  input  logic [DATA_WIDTH/8-1:0]        m_pstb,
  output logic                           m_pready,
  output logic                           m_perr,
  output logic [ADDR_WIDTH-1:0]          s_paddr,
  output logic [DATA_WIDTH-1:0]          s_pwdata,
  output logic                           s_pwrite,
  output logic [DATA_WIDTH/8-1:0]        s_pstb,
  output logic [NUM_SLAVES-1:0]          s_psel,
  output logic [NUM_SLAVES-1:0]          s_penable,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_prdata,
  input  logic [NUM_SLAVES-1:0]          s_pready,
  input  logic [NUM_SLAVES-1:0]          s_perr
);

  localparam int IDXW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int SW   = DATA_WIDTH / 8;
  localparam logic [IDXW:0] NSL = (IDXW+1)'(NUM_SLAVES);

  // Elaboration-time parameter sanity checks
  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_ns
    $error("apb_fabric: NUM_SLAVES out of range 1..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_to
    $error("apb_fabric: TIMEOUT_CYCLES out of range 1..65535");
  end
  if (SEL_LSB + IDXW > ADDR_WIDTH) begin : g_bad_sel
    $error("apb_fabric: slave index field exceeds address width");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP,
    ST_DECERR
  } state_e;

  state_e                  state_q;
  logic [IDXW-1:0]         idx_q;
  logic                    abort_q;
  logic [ADDR_WIDTH-1:0]   s_paddr_q;
  logic [DATA_WIDTH-1:0]   s_pwdata_q;
  logic                    s_pwrite_q;
  logic [SW-1:0]           s_pstb_q;
  logic [NUM_SLAVES-1:0]   s_psel_q;
  logic [NUM_SLAVES-1:0]   s_penable_q;
  logic [DATA_WIDTH-1:0]   m_prdata_q;
  logic                    m_pready_q;
  logic                    m_perr_q;

`ifdef APB_FABRIC_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]             cnt_q;
`endif

  logic [IDXW-1:0]         m_idx;
  logic                    m_hit;
  logic [NUM_SLAVES-1:0]   m_dec;
  logic                    sel_rdy;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    req_gone;

  assign m_idx    = m_paddr[SEL_LSB +: IDXW];
  assign m_hit    = {1'b0, m_idx} < NSL;
  assign req_gone = abort_q | ~m_psel;

  // One-hot select pattern for the incoming request's slave index
  always_comb begin
    m_dec = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      m_dec[i] = (m_idx == IDXW'(i));
    end
  end

  // Pick ready/error/read data of the selected slave only
  always_comb begin
    sel_rdy   = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDXW'(i)) begin
        sel_rdy   = s_pready[i];
        sel_err   = s_perr[i];
        sel_rdata = s_prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Transfer FSM with registered broadcast and response outputs
  always_ff @(posedge clk or negedge rts) begin
    if (!rts) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      abort_q     <= 1'b0;
      s_paddr_q   <= '0;
      s_pwdata_q  <= '0;
      s_pwrite_q  <= 1'b0;
      s_pstb_q    <= '0;
      s_psel_q    <= '0;
      s_penable_q <= '0;
      m_prdata_q  <= '0;
      m_pready_q  <= 1'b0;
      m_perr_q    <= 1'b0;
`ifdef APB_FABRIC_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          m_pready_q <= 1'b0;
          if (m_psel && !m_penable) begin
            s_paddr_q  <= m_paddr;
            s_pwdata_q <= m_pwdata;
            s_pwrite_q <= m_pwrite;
            s_pstb_q   <= m_pstb;
            idx_q      <= m_idx;
            abort_q    <= 1'b0;
            if (m_hit) begin
              s_psel_q <= m_dec;
              state_q  <= ST_SETUP;
            end else begin
              state_q  <= ST_DECERR;
            end
          end
        end

        ST_SETUP: begin
          s_penable_q <= s_psel_q;
          if (!m_psel) abort_q <= 1'b1;
`ifdef APB_FABRIC_TIMEOUT_EN
          cnt_q       <= '0;
`endif
          state_q     <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (!m_psel) abort_q <= 1'b1;
          if (sel_rdy) begin
            s_psel_q    <= '0;
            s_penable_q <= '0;
            if (req_gone) begin
              state_q <= ST_IDLE;
            end else begin
              m_prdata_q <= s_pwrite_q ? '0 : sel_rdata;
              m_perr_q   <= sel_err;
              m_pready_q <= 1'b1;
              state_q    <= ST_RESP;
            end
          end
`ifdef APB_FABRIC_TIMEOUT_EN
          else if (cnt_q == TO_LIM) begin
            s_psel_q    <= '0;
            s_penable_q <= '0;
            if (req_gone) begin
              state_q <= ST_IDLE;
            end else begin
              m_prdata_q <= '0;
              m_perr_q   <= 1'b1;
              m_pready_q <= 1'b1;
              state_q    <= ST_RESP;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end

        ST_RESP: begin
          m_pready_q <= 1'b0;
          state_q    <= ST_IDLE;
        end

        ST_DECERR: begin
          if (req_gone) begin
            state_q <= ST_IDLE;
          end else begin
            m_prdata_q <= '0;
            m_perr_q   <= 1'b1;
            m_pready_q <= 1'b1;
            state_q    <= ST_RESP;
          end
        end

        default: begin
          s_psel_q    <= '0;
          s_penable_q <= '0;
          m_pready_q  <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_paddr   = s_paddr_q;
  assign s_pwdata  = s_pwdata_q;
  assign s_pwrite  = s_pwrite_q;
  assign s_pstb    = s_pstb_q;
  assign s_psel    = s_psel_q;
  assign s_penable = s_penable_q;
  assign m_prdata  = m_prdata_q;
  assign m_pready  = m_pready_q;
  assign m_perr    = m_perr_q;

endmodule

// File: tb/tb_apb_fabric.sv
// tb_apb_fabric: scoreboard bench for apb_fabric with three behavioural slaves.
// Timeout case runs only when APB_FABRIC_TIMEOUT_EN is defined.
module tb_apb_fabric;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int SW = DW / 8;

  logic               clk;
  logic               rts;
  logic [AW-1:0]      m_paddr;
  logic [DW-1:0]      m_pwdata;
  logic [DW-1:0]      m_prdata;
  logic               m_psel;
  logic               m_penable;
  logic               m_pwrite;
  logic [SW-1:0]      m_pstb;
  logic               m_pready;
  logic               m_perr;
  logic [AW-1:0]      s_paddr;
  logic [DW-1:0]      s_pwdata;
  logic               s_pwrite;
  logic [SW-1:0]      s_pstb;
  logic [NS-1:0]      s_psel;
  logic [NS-1:0]      s_penable;
  logic [NS*DW-1:0]   s_prdata;
  logic [NS-1:0]      s_pready;
  logic [NS-1:0]      s_perr;

  apb_fabric #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .NUM_SLAVES    (NS),
    .SEL_LSB       (28),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rts      (rts),
    .m_paddr  (m_paddr),
    .m_pwdata (m_pwdata),
    .m_prdata (m_prdata),
    .m_psel   (m_psel),
    .m_penable(m_penable),
    .m_pwrite (m_pwrite),
    .m_pstb   (m_pstb),
    .m_pready (m_pready),
    .m_perr   (m_perr),
    .s_paddr  (s_paddr),
    .s_pwdata (s_pwdata),
    .s_pwrite (s_pwrite),
    .s_pstb   (s_pstb),
    .s_psel   (s_psel),
    .s_penable(s_penable),
    .s_prdata (s_prdata),
    .s_pready (s_pready),
    .s_perr   (s_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural slaves: ready after stall[i] ACCESS cycles
  logic [DW-1:0] sl_data [NS];
  int            stall   [NS];
  bit            never   [NS];
  int            acc     [NS];
  logic [NS-1:0] perr_cfg;

  initial begin
    for (int i = 0; i < NS; i++) begin
      acc[i]   = 0;
      stall[i] = 0;
      never[i] = 1'b0;
    end
    sl_data[0] = 32'hA5A5_0000;
    sl_data[1] = 32'hDEAD_BEEF;
    sl_data[2] = 32'hC0DE_2222;
  end

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      acc[i] <= s_penable[i] ? acc[i] + 1 : 0;
    end
  end

  always_comb begin
    s_pready = '0;
    s_prdata = '0;
    for (int i = 0; i < NS; i++) begin
      s_pready[i] = s_penable[i] && !never[i] && (acc[i] >= stall[i]);
      s_prdata[i*DW +: DW] = sl_data[i];
    end
  end

  assign s_perr = perr_cfg;

  // Scoreboard
  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    int            c;
  } exp_t;

  exp_t q[$];
  exp_t ex;
  int total = 0;
  int bad   = 0;

  logic          hold_on;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_wr;
  logic [SW-1:0] h_stb;
  logic [NS-1:0] h_sel;

  // Monitor: pops on every m_pready and checks broadcast hold
  always @(negedge clk) begin
    if (rts && m_pready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected got d=%h e=%b cyc=%0d",
                 m_prdata, m_perr, cyc);
      end else begin
        ex = q.pop_front();
        if (m_prdata !== ex.d || m_perr !== ex.e || cyc != ex.c) begin
          bad++;
          $display("FAIL resp got d=%h e=%b cyc=%0d want d=%h e=%b cyc=%0d",
                   m_prdata, m_perr, cyc, ex.d, ex.e, ex.c);
        end
      end
    end
    if (hold_on) begin
      total++;
      if (s_paddr !== h_addr || s_pwdata !== h_wdata ||
          s_pwrite !== h_wr || s_pstb !== h_stb ||
          (s_psel & ~h_sel) != '0 || (s_penable & ~h_sel) != '0) begin
        bad++;
        $display("FAIL hold got a=%h d=%h w=%b s=%b sel=%b en=%b want a=%h d=%h w=%b s=%b sel<=%b",
                 s_paddr, s_pwdata, s_pwrite, s_pstb, s_psel, s_penable,
                 h_addr, h_wdata, h_wr, h_stb, h_sel);
      end
    end
  end

  task automatic check_zero(input string nm);
    total++;
    if (m_prdata !== '0 || m_pready !== 1'b0 || m_perr !== 1'b0 ||
        s_paddr !== '0 || s_pwdata !== '0 || s_pwrite !== 1'b0 ||
        s_pstb !== '0 || s_psel !== '0 || s_penable !== '0) begin
      bad++;
      $display("FAIL %s got rd=%h rdy=%b err=%b a=%h d=%h w=%b s=%b sel=%b en=%b want all zero",
               nm, m_prdata, m_pready, m_perr, s_paddr, s_pwdata,
               s_pwrite, s_pstb, s_psel, s_penable);
    end
  endtask

  // One requester transfer; called at posedge+1
  task automatic xfer(input logic [AW-1:0] a, input logic w,
                      input logic [DW-1:0] wd, input logic [SW-1:0] stb,
                      input logic [NS-1:0] sel, input logic [DW-1:0] ed,
                      input logic ee, input int lat);
    int n;
    m_paddr   = a;
    m_pwrite  = w;
    m_pwdata  = wd;
    m_pstb    = stb;
    m_psel    = 1'b1;
    m_penable = 1'b0;
    q.push_back('{ed, ee, cyc + lat});
    h_addr  = a;
    h_wdata = wd;
    h_wr    = w;
    h_stb   = stb;
    h_sel   = sel;
    @(posedge clk);
    #1;
    m_penable = 1'b1;
    hold_on   = 1'b1;
    n = 0;
    while (!m_pready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL xfer_timeout addr=%h got no m_pready want pready", a);
      q.delete();
    end
    @(posedge clk);
    #1;
    hold_on   = 1'b0;
    m_psel    = 1'b0;
    m_penable = 1'b0;
  endtask

  initial begin
    rts       = 1'b0;
    m_paddr   = '0;
    m_pwdata  = '0;
    m_pwrite  = 1'b0;
    m_pstb    = '0;
    m_psel    = 1'b0;
    m_penable = 1'b0;
    perr_cfg  = 3'b100;
    hold_on   = 1'b0;
    h_addr    = '0;
    h_wdata   = '0;
    h_wr      = 1'b0;
    h_stb     = '0;
    h_sel     = '0;

    #22;
    check_zero("reset_state");
    @(posedge clk);
    #3;
    rts = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait read of slave 1
    xfer(32'h1000_0004, 1'b0, '0, 4'hF, 3'b010, 32'hDEAD_BEEF, 1'b0, 3);

    // Write to slave 0, five stall cycles
    stall[0] = 5;
    xfer(32'h0000_0010, 1'b1, 32'h1234_5678, 4'b0011, 3'b001,
         32'h0, 1'b0, 8);
    stall[0] = 0;

    // Write to slave 1, two stall cycles
    stall[1] = 2;
    xfer(32'h1000_0000, 1'b1, 32'hCAFE_F00D, 4'b1111, 3'b010,
         32'h0, 1'b0, 5);
    stall[1] = 0;

    // Unmapped indices
    xfer(32'h3000_0000, 1'b0, '0, 4'hF, 3'b000, 32'h0, 1'b1, 2);
    xfer(32'hF000_0040, 1'b1, 32'h5555_AAAA, 4'b1000, 3'b000,
         32'h0, 1'b1, 2);

    // Back-to-back reads, slave 0 then slave 2 (slave 2 flags error)
    xfer(32'h0000_0000, 1'b0, '0, 4'hF, 3'b001, 32'hA5A5_0000, 1'b0, 3);
    xfer(32'h2000_0000, 1'b0, '0, 4'hF, 3'b100, 32'hC0DE_2222, 1'b1, 3);

`ifdef APB_FABRIC_TIMEOUT_EN
    // Slave 2 never ready: eight ACCESS cycles then error
    never[2] = 1'b1;
    xfer(32'h2000_0004, 1'b0, '0, 4'hF, 3'b100, 32'h0, 1'b1, 10);
    never[2] = 1'b0;
`endif

    // Reset in the middle of a stalled slave-1 read
    stall[1]  = 30;
    m_paddr   = 32'h1000_0008;
    m_pwrite  = 1'b0;
    m_pwdata  = 32'h0BAD_0BAD;
    m_pstb    = 4'hF;
    m_psel    = 1'b1;
    m_penable = 1'b0;
    @(posedge clk);
    #1;
    m_penable = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (s_penable !== 3'b010 || s_psel !== 3'b010) begin
      bad++;
      $display("FAIL mid_access got sel=%b en=%b want sel=010 en=010",
               s_psel, s_penable);
    end
    #2;
    rts = 1'b0;
    #1;
    check_zero("async_reset");
    m_psel    = 1'b0;
    m_penable = 1'b0;
    @(posedge clk);
    #3;
    rts = 1'b1;
    stall[1] = 0;
    @(posedge clk);
    #1;
    xfer(32'h0000_0020, 1'b0, '0, 4'hF, 3'b001, 32'hA5A5_0000, 1'b0, 3);

    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_fabric.md
# apb_fabric

Parametrised APB interconnect between one APB requester (the CPU) and `NUM_SLAVES` APB completers (SRAM, UART, future peripherals). It replaces the fixed two-slave decoder with a registered, address-decoded fabric. It returns an error response for unmapped addresses and, optionally, for slaves that never assert ready. Request fields are registered once and broadcast downstream; read data and error status are registered back to the requester.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width; strobe width is `DATA_WIDTH/8`.
- `NUM_SLAVES`, 2, number of completer ports, 1..16.
- `SEL_LSB`, 28, lowest address bit of the slave index field; field width `IDXW = max(1, clog2(NUM_SLAVES))`.
- `TIMEOUT_CYCLES`, 255, ACCESS cycles allowed before timeout; range 1..65535.

Ports:
- `clk` in 1: clock, rising edge.
- `rts` in 1: reset; **single clock `clk`; reset `rts` is asynchronous, active-low.**
- `m_paddr` in `ADDR_WIDTH`: requester address.
- `m_pwdata` in `DATA_WIDTH`: requester write data.
- `m_prdata` out `DATA_WIDTH`: read data to requester.
- `m_psel`, `m_penable`, `m_pwrite` in 1: requester APB controls.
- `m_pstb` in `DATA_WIDTH/8`: byte strobes.
- `m_pready`, `m_perr` out 1: completion and error.
- `s_paddr` out `ADDR_WIDTH`: registered broadcast address.
- `s_pwdata` out `DATA_WIDTH`: registered broadcast write data.
- `s_pwrite` out 1: registered broadcast write flag.
- `s_pstb` out `DATA_WIDTH/8`: registered broadcast strobes.
- `s_psel`, `s_penable` out `NUM_SLAVES`: one-hot per-slave select and enable.
- `s_prdata` in `NUM_SLAVES*DATA_WIDTH`: slave i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_pready`, `s_perr` in `NUM_SLAVES`: per-slave ready and error.

## Operation
- States: IDLE, SETUP, ACCESS, RESP, DECERR.
- **IDLE.** When `m_psel=1` and `m_penable=0`:
  - Latch `m_paddr`, `m_pwdata`, `m_pwrite`, `m_pstb` into the `s_*` broadcast registers.
  - Decode `idx = m_paddr[SEL_LSB +: IDXW]`.
  - If `idx < NUM_SLAVES`, go to SETUP; otherwise go to DECERR.
- **SETUP.** `s_psel[idx]=1`, `s_penable=0`. Always go to ACCESS on the next cycle.
- **ACCESS.** `s_psel[idx]=1`, `s_penable[idx]=1`. Stay until `s_pready[idx]=1`, then:
  - On a read, capture `s_prdata` slice `idx` into `m_prdata`; on a write, set `m_prdata=0`.
  - Capture `s_perr[idx]` into `m_perr`.
  - Go to RESP.
- **RESP.** `m_pready=1` for exactly one cycle, with the held `m_prdata`/`m_perr`. `s_psel=0`. Go to IDLE.
- **DECERR.** No slave selected. The next cycle presents `m_pready=1`, `m_perr=1`, `m_prdata=0` for one cycle. Go to IDLE.
- **Ready/error hygiene:**
  - `s_pready`/`s_perr` of unselected slaves are ignored.
  - `m_pready` is never asserted outside RESP or the DECERR response cycle.
- **Requester abort** (`m_psel` drops before `m_pready`): the downstream transfer still completes, the response is discarded (no `m_pready` pulse), and the state returns to IDLE.
- **Hold rule:** broadcast `s_*` registers change only on an IDLE→SETUP/DECERR transition. They hold through the whole transfer, including stalled ACCESS.
- **Reset** (`rts=0`, at any point including mid-ACCESS):
  - State goes to IDLE.
  - `s_psel=0`, `s_penable=0`, `m_pready=0`, `m_perr=0`.
  - `m_prdata`, `s_paddr`, `s_pwdata`, `s_pwrite`, `s_pstb` go to 0.
  - The timeout counter goes to 0.

## Timing
- Zero-wait slave read/write: requester SETUP in cycle 0, fabric SETUP in cycle 1, ACCESS in cycle 2 (`s_pready=1`), `m_pready` in cycle 3. The requester sees 2 wait states.
- Each cycle the slave stalls (`s_pready=0`) adds one cycle.
- DECERR: `m_pready`/`m_perr` in cycle 2.
- Back-to-back transfers: the fabric is in IDLE in the cycle after RESP and samples a new SETUP there. Throughput is one transfer per 4 cycles.
- All outputs are registered; there are no combinational paths from `m_*` inputs to `s_*` outputs or from `s_*` inputs to `m_*` outputs.

## Configuration
- Macro `APB_FABRIC_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter clears on SETUP and increments each ACCESS cycle with `s_pready[idx]=0`.
  - When the counter reaches `TIMEOUT_CYCLES` without ready, drop `s_psel`/`s_penable` and go to RESP with `m_perr=1`, `m_prdata=0`.
  - A ready in the same cycle the counter reaches the limit wins: normal completion.
- **Undefined:** no counter; ACCESS waits indefinitely for `s_pready[idx]`.

## Test plan
Bench uses `NUM_SLAVES=3`, `SEL_LSB=28`.
- Read `0x1000_0004`; slave 1 returns `0xDEAD_BEEF`, zero-wait → `s_psel=3'b010`; `m_prdata=0xDEADBEEF`, `m_perr=0`, `m_pready` in cycle 3.
- Write `0x0000_0010`, data `0x1234_5678`, `pstb=4'b0011`; slave 0 stalls 5 cycles → `s_*` held constant throughout; `m_pready` in cycle 8; `m_perr=0`.
- Read `0x3000_0000` (unmapped index 3) → no `s_psel` bit set; `m_pready=1`, `m_perr=1`, `m_prdata=0` in cycle 2.
- With `APB_FABRIC_TIMEOUT_EN` and `TIMEOUT_CYCLES=8`, slave 2 never ready → `s_psel` drops after 8 ACCESS cycles; `m_perr=1`.
- Assert `rts=0` mid-ACCESS of a slave-1 read → all outputs 0 asynchronously; after release, a new read to slave 0 completes normally.
- Two back-to-back reads to slaves 0 then 2 → second SETUP sampled the cycle after the first `m_pready`; each transfer takes 4 cycles.
